spi_master_multi: RTL
=====================

SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

Interface
REQ-001 Parameter DATA_W, default 32: maximum transaction width in bits; a multiple of 8, at least 8.
REQ-002 Parameter CS_COUNT, default 4: number of chip-select lines, at least 1.
REQ-003 Parameter DIV_W, default 8: width of the clock-divider input.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  request a transaction; sampled only when the block is idle.
REQ-007 cs_sel  in  max(1,clog2(CS_COUNT))  index of the slave to address.
REQ-008 len  in  clog2(DATA_W/8) (min 1)  transaction length in bytes minus 1.
REQ-009 div  in  DIV_W  SCLK half-period, equal to div+1 clk cycles.
REQ-010 cpol, cpha, lsb_first  in  1 each  SPI mode and bit order.
REQ-011 tx_data  in  DATA_W  transmit word; bits [8*(len+1)-1:0] are sent.
REQ-012 rx_data  out  DATA_W  received word, right-aligned; unused upper bits are 0.
REQ-013 busy  out  1  high from the cycle after acceptance until done.
REQ-014 done  out  1  one-cycle pulse when a transaction completes.
REQ-015 err  out  1  one-cycle pulse when a start is rejected.
REQ-016 sclk, mosi  out  1 each; miso  in  1; cs_n  out  CS_COUNT  active-low selects.

Function
REQ-017 Acceptance: when start=1 and busy=0 and cs_sel<CS_COUNT, the block shall latch cs_sel, len, div, cpol, cpha, lsb_first and tx_data; these latched values shall not change until the transaction ends.
REQ-018 Rejection: when start=1 and busy=0 and cs_sel>=CS_COUNT, the block shall not start a transaction and shall pulse err on the next cycle; start while busy=1 shall be ignored with no err.
REQ-019 FSM states and transitions:
- IDLE -> SETUP on acceptance.
- SETUP -> XFER after div+1 cycles.
- XFER -> HOLD after 2*N half-periods, where N=8*(len+1).
- HOLD -> IDLE after div+1 cycles.
REQ-020 busy shall rise in the cycle after acceptance. In the cycle that HOLD exits, busy shall fall, done shall pulse and rx_data shall update; at all other times rx_data holds its value.
REQ-021 cs_n[sel] shall be low throughout SETUP, XFER and HOLD; all other cs_n bits shall stay high; all cs_n bits shall be high in IDLE.
REQ-022 sclk shall equal the latched cpol in IDLE, SETUP and HOLD, and shall toggle every div+1 cycles in XFER for exactly 2*N edges.
REQ-023 Bit order: with lsb_first=0, bit N-1 is sent first; with lsb_first=1, bit 0 is sent first. Received bits shall be placed in the same order, so that the first bit received lands at the position of the first bit sent.
REQ-024 cpha=0:
- first bit on mosi from SETUP entry;
- miso sampled on odd (leading) edges;
- mosi advances on even (trailing) edges, except after the last edge.
REQ-025 cpha=1:
- mosi advances on odd (leading) edges, first bit presented on edge 1;
- miso sampled on even (trailing) edges.
REQ-026 mosi shall be 0 in IDLE.
REQ-027 Boundaries:
- div=0 gives a half-period of 1 cycle.
- len at maximum transfers DATA_W bits.
- A start presented in the done cycle shall be accepted (back-to-back transactions).
- A change of div, cpol or other inputs during a transaction has no effect.

Reset
REQ-028 While rst=0, asynchronously and regardless of state:
- the FSM shall return to IDLE;
- cs_n = all 1s; sclk = 0; mosi = 0;
- busy = 0; done = 0; err = 0; rx_data = 0;
- internal counters shall clear.
REQ-029 After rst releases, the first accepted start shall behave exactly as from power-up. A transaction interrupted by reset shall produce no done pulse.

Verification
REQ-030 Mode 0, MSB first, div=1, len=0, cs_sel=2, tx_data=0xA5, loopback slave returning 0x3C -> mosi carries 10100101; cs_n=1011 during the transaction; 16 sclk edges, 2 cycles apart; done pulse; rx_data=0x0000003C.
REQ-031 All four cpol/cpha modes, len=3, tx_data=0xDEADBEEF, miso looped to mosi -> rx_data=0xDEADBEEF; sclk idles at cpol; 64 edges per transaction.
REQ-032 lsb_first=1, len=1, tx_data=0x1234 -> first mosi bits 0,0,1,0 (LSB first); loopback rx_data=0x00001234.
REQ-033 cs_sel=5 with CS_COUNT=4 -> err pulses 1 cycle; busy stays 0; cs_n stays 1111. Start while busy -> ignored, no err.
REQ-034 rst low in the middle of XFER -> in the same cycle: cs_n=1111, sclk=0, busy=0, no done. A new transaction after release completes correctly.
REQ-035 Start asserted in the done cycle with div=0 -> second transaction begins; busy goes 0 for exactly 1 cycle; both rx_data values are correct.

Source files
------------

// File: rtl/spi_master_multi.sv
// SPI master with several chip selects, selectable mode, bit order and per-transaction
// length in bytes. Every setting is latched at start, so the bus stays stable mid-transfer.
module spi_master_multi #(
    parameter int DATA_W   = 32,
    parameter int CS_COUNT = 4,
    parameter int DIV_W    = 8,
    localparam int SEL_W   = (CS_COUNT > 1) ? $clog2(CS_COUNT) : 1,
    localparam int LEN_W   = (DATA_W / 8 > 1) ? $clog2(DATA_W / 8) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [SEL_W-1:0]    cs_sel,
    input  logic [LEN_W-1:0]    len,
    input  logic [DIV_W-1:0]    div,
    input  logic                cpol,
    input  logic                cpha,
    input  logic                lsb_first,
    input  logic [DATA_W-1:0]   tx_data,
    output logic [DATA_W-1:0]   rx_data,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                sclk,
    output logic                mosi,
    input  logic                miso,
    output logic [CS_COUNT-1:0] cs_n
);

    localparam int IDX_W  = LEN_W + 3;
    localparam int ECNT_W = IDX_W + 2;
    localparam logic [SEL_W:0] CS_LIMIT = CS_COUNT[SEL_W:0];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD
    } state_t;

    state_t              state;
    logic [DIV_W-1:0]    cnt;
    logic [ECNT_W-1:0]   ecnt;
    logic [LEN_W-1:0]    len_l;
    logic [DIV_W-1:0]    div_l;
    logic                cpha_l;
    logic                lsb_l;
    logic [DATA_W-1:0]   tx_l;
    logic [DATA_W-1:0]   rx_shift;

    logic                cs_ok;
    logic                last_edge;
    logic [IDX_W-1:0]    k;

    // The k-th bit on the wire lives at k (LSB first) or N-1-k (MSB first); rx uses the same map.
    function automatic logic [IDX_W-1:0] bit_pos(input logic lsb, input logic [LEN_W-1:0] l,
                                                 input logic [IDX_W-1:0] idx);
        return lsb ? idx : ({l, 3'b111} - idx);
    endfunction

    assign cs_ok     = ({1'b0, cs_sel} < CS_LIMIT);
    assign k         = ecnt[IDX_W:1];
    assign last_edge = (ecnt == {1'b0, len_l, 4'b1111});

    // NOTE: every register, shift and latch registers included, sits in the async reset branch
    // so the first start after reset behaves exactly like the first start after power-up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            ecnt     <= '0;
            len_l    <= '0;
            div_l    <= '0;
            cpha_l   <= 1'b0;
            lsb_l    <= 1'b0;
            tx_l     <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= '1;
        end else begin
            // NOTE: pulses default low here, so each assignment below lasts exactly one cycle.
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (cs_ok) begin
                            state    <= ST_SETUP;
                            busy     <= 1'b1;
                            cs_n     <= ~(CS_COUNT'(1) << cs_sel);
                            sclk     <= cpol;
                            len_l    <= len;
                            div_l    <= div;
                            cpha_l   <= cpha;
                            lsb_l    <= lsb_first;
                            tx_l     <= tx_data;
                            rx_shift <= '0;
                            cnt      <= '0;
                            ecnt     <= '0;
                            mosi     <= cpha ? 1'b0 : tx_data[bit_pos(lsb_first, len, IDX_W'(0))];
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    if (cnt == div_l) begin
                        cnt   <= '0;
                        state <= ST_XFER;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_XFER: begin
                    if (cnt == div_l) begin
                        cnt  <= '0;
                        sclk <= ~sclk;
                        ecnt <= ecnt + 1'b1;
                        // ecnt[0]==0 marks a leading edge; cpha picks which edge samples.
                        if (ecnt[0] == cpha_l)
                            rx_shift[bit_pos(lsb_l, len_l, k)] <= miso;
                        else if (cpha_l)
                            mosi <= tx_l[bit_pos(lsb_l, len_l, k)];
                        else if (!last_edge)
                            mosi <= tx_l[bit_pos(lsb_l, len_l, k + 1'b1)];
                        if (last_edge)
                            state <= ST_HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == div_l) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rx_data <= rx_shift;
                        cs_n    <= '1;
                        mosi    <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
